// File: rtl/rv32e_pkg.sv
// Shared definitions for the RV32E front end: fetch FSM states, instruction
// size, and the opcode/funct encodings used by both fetch and decode.
package rv32e_pkg;

    // Size of one instruction word in bytes; the PC advances by this amount.
    localparam int INSTR_BYTES = 4;

    // Fetch-stage control states.
    typedef enum logic [1:0] {
        FETCH = 2'd0,  // request presented to instruction memory
        WAIT  = 2'd1,  // request accepted, awaiting response
        HOLD  = 2'd2,  // instruction presented to the decoder
        FAULT = 2'd3   // misaligned redirect seen; only reset leaves
    } fetch_state_t;

    // Major opcodes (instr[6:0]).
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    // Branch comparison selects (funct3 of OP_BRANCH).
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_t;

    // ALU operation selects (funct3 of OP_IMM / OP_REG).
    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SLT     = 3'b010,
        F3_SLTU    = 3'b011,
        F3_XOR     = 3'b100,
        F3_SRL_SRA = 3'b101,
        F3_OR      = 3'b110,
        F3_AND     = 3'b111
    } alu_funct3_t;

    // Load/store width selects (funct3 of OP_LOAD / OP_STORE).
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } mem_funct3_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight,
// hands each returned word (with its PC) to the decoder, and applies
// redirects from execute. A misaligned redirect parks the stage in FAULT.
module instruction_fetch
    import rv32e_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_encoded,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    // Set when the outstanding request belongs to a superseded PC; its
    // response must be thrown away instead of reaching the decoder.
    logic            drop;

    logic redirect_ok;
    logic redirect_bad;

    assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Request side decodes straight from state and PC so a request goes out
    // in the same cycle the FSM enters FETCH.
    assign mem_req_valid = (state == FETCH);
    assign mem_req_addr  = pc;

    // Fetch control, PC and decoder-facing registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every branch
        // below reads the pre-edge values regardless of statement order.
        if (reset) begin
            state         <= FETCH;
            pc            <= {RESET_PC[XLEN-1:2], 2'b00};
            drop          <= 1'b0;
            instr_valid   <= 1'b0;
            instr_encoded <= '0;
            instr_pc      <= '0;
            fetch_fault   <= 1'b0;
        end else if (state == FAULT) begin
            // Sticky until reset: requests stop, responses and redirects ignored.
            state <= FAULT;
        end else if (redirect_bad) begin
            fetch_fault <= 1'b1;
            instr_valid <= 1'b0;
            state       <= FAULT;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_ok) begin
                        pc <= redirect_pc;
                        // The old-address request was still accepted; its
                        // response is stale and must be discarded.
                        if (mem_req_ready) begin
                            drop  <= 1'b1;
                            state <= WAIT;
                        end
                    end else if (mem_req_ready) begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (redirect_ok) begin
                        pc <= redirect_pc;
                        if (mem_resp_valid) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (mem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            instr_encoded <= mem_resp_data;
                            instr_pc      <= pc;
                            instr_valid   <= 1'b1;
                            pc            <= pc + XLEN'(INSTR_BYTES);
                            state         <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    // A redirect kills the held instruction even if the
                    // decoder is taking it this cycle.
                    if (redirect_ok) begin
                        instr_valid <= 1'b0;
                        pc          <= redirect_pc;
                        state       <= FETCH;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end

                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a behavioural memory with variable
// latency and stray responses, a randomly stalling decoder, random redirects
// (aligned, wrap-around, misaligned) and random resets, all checked each cycle
// against a transaction-level model of the fetch stage.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          CYCLES = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_encoded;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    instruction_fetch #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_encoded  (instr_encoded),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    endtask

    // Memory image: each word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]} ^ 32'h0050_0093;
    endfunction

    // Reference model: the stage is described by what it holds, not by an FSM.
    //   m_inflight : a request is accepted and its response not yet seen
    //   m_stale    : that in-flight request belongs to an abandoned PC
    //   m_held     : an instruction is being offered to the decoder
    logic [31:0] m_pc, m_word, m_wpc;
    bit          m_inflight, m_stale, m_held, m_fault;

    task automatic model_reset();
        m_pc       = RST_PC;
        m_inflight = 0;
        m_stale    = 0;
        m_held     = 0;
        m_word     = '0;
        m_wpc      = '0;
        m_fault    = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit requesting;
        requesting = !m_fault && !m_inflight && !m_held;
        if (reset) begin
            model_reset();
        end else if (m_fault) begin
            // stays faulted
        end else if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
            m_fault    = 1;
            m_held     = 0;
            m_inflight = 0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc;
            if (m_held) begin
                m_held = 0;
            end else if (m_inflight) begin
                if (mem_resp_valid) begin
                    m_inflight = 0;
                    m_stale    = 0;
                end else begin
                    m_stale = 1;
                end
            end else if (requesting && mem_req_ready) begin
                m_inflight = 1;
                m_stale    = 1;
            end
        end else if (m_held) begin
            if (instr_ready) m_held = 0;
        end else if (m_inflight) begin
            if (mem_resp_valid) begin
                m_inflight = 0;
                if (m_stale) begin
                    m_stale = 0;
                end else begin
                    m_held = 1;
                    m_word = mem_resp_data;
                    m_wpc  = m_pc;
                    m_pc   = m_pc + 32'd4;
                end
            end
        end else if (mem_req_ready) begin
            m_inflight = 1;
            m_stale    = 0;
        end
    endtask

    // Behavioural memory: one pending request, 1..3 cycle response latency.
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_delay;

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = 32'hFFFF_FFFC;
            1:       t = 32'h0000_0200 + 32'($urandom_range(0, 63)) * 4;
            default: t = {$urandom, 2'b00} >> 0;
        endcase
        t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        int fault_len;
        bit exp_req;

        reset          = 1'b1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_pend       = 0;
        mem_addr       = '0;
        mem_delay      = 0;
        fault_len      = 0;
        model_reset();
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);

            // Compare every DUT output against the model.
            exp_req = !m_fault && !m_inflight && !m_held;
            check("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
            if (exp_req) check("mem_req_addr", mem_req_addr, m_pc);
            check("instr_valid", 32'(instr_valid), 32'(m_held));
            check("instr_encoded", instr_encoded, m_word);
            check("instr_pc", instr_pc, m_wpc);
            check("fetch_fault", 32'(fetch_fault), 32'(m_fault));

            // Reset: occasionally at random, and always after a spell in FAULT.
            fault_len = m_fault ? fault_len + 1 : 0;
            reset = (fault_len > 12) || ($urandom_range(0, 199) == 0);

            // Memory response: pending one when due, otherwise a rare stray.
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (mem_pend) begin
                if (mem_delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(mem_addr);
                    mem_pend       = 0;
                end else begin
                    mem_delay--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                mem_resp_valid = 1'b1;
            end

            // Memory accepts a new request only when nothing is pending.
            mem_req_ready = !mem_pend && ($urandom_range(0, 3) != 0);
            if (mem_req_valid && mem_req_ready) begin
                mem_pend  = 1;
                mem_addr  = mem_req_addr;
                mem_delay = $urandom_range(0, 2);
            end

            // Decoder stalls about a third of the time.
            instr_ready = ($urandom_range(0, 2) != 0);

            // Redirects: mostly aligned, occasionally misaligned.
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = pick_target();
            if (redirect_valid && $urandom_range(0, 9) == 0)
                redirect_pc[1:0] = 2'($urandom_range(1, 3));

            model_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
